alu_seq: RTL and testbench

Parametrised sequential ALU for the datapath, the successor to the combinational `alu`. It keeps the opcode map and adds a valid/ready input handshake. Flags are held in an internal NZCV register, so carry-consuming ops (ADCS, SBCS) read the stored C flag instead of an external `cin`. Multiply is an iterative shift-add unit, so a full-width multiplier is not needed. It sits between the operand-fetch stage and writeback.

---
 rtl/alu_seq.sv | 207 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready input handshake, an internal NZCV
// flag register feeding carry-consuming ops, and an iterative shift-add
// multiplier. Single-cycle ops complete at the accepting edge; MULS occupies
// the unit for WIDTH-1 further cycles.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       nzcv,
  output logic             err
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADCS = 4'b0001;
  localparam logic [3:0] OP_ANDS = 4'b0010;
  localparam logic [3:0] OP_ORRS = 4'b0011;
  localparam logic [3:0] OP_RSBS = 4'b0100;
  localparam logic [3:0] OP_SBCS = 4'b0101;
  localparam logic [3:0] OP_SUBS = 4'b0110;
  localparam logic [3:0] OP_CMP  = 4'b0111;
  localparam logic [3:0] OP_MULS = 4'b1000;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Shared adder: returns {carry_out, sum}.
  function automatic logic [WIDTH:0] adder(input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y,
                                           input logic             cin);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
  endfunction

  // Signed overflow: adder inputs agree in sign but the sum does not.
  function automatic logic overflow(input logic x_msb, input logic y_msb,
                                    input logic r_msb);
    return (x_msb == y_msb) && (r_msb != x_msb);
  endfunction

  logic [0:0]       state_q,     state_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic [3:0]       nzcv_q,      nzcv_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q,       err_d;
  logic [WIDTH-1:0] acc_q,       acc_d;
  logic [WIDTH-1:0] mcand_q,     mcand_d;
  logic [WIDTH-1:0] mplier_q,    mplier_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  logic             accept;
  logic             c_flag;
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] add_res;
  logic             add_v;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] prod;

  assign accept  = in_valid && (state_q == ST_IDLE);
  assign c_flag  = nzcv_q[1];

  // Route operands onto the single adder; subtraction is x + ~y + cin.
  always_comb begin
    add_x   = a;
    add_y   = ~b;
    add_cin = 1'b1;
    case (opcode)
      OP_ADD: begin
        add_y   = b;
        add_cin = 1'b0;
      end
      OP_ADCS: begin
        add_y   = b;
        add_cin = c_flag;
      end
      OP_RSBS: begin
        add_x   = b;
        add_y   = ~a;
      end
      OP_SBCS: begin
        add_cin = c_flag;
      end
      default: begin
        add_x   = a;
        add_y   = ~b;
        add_cin = 1'b1;
      end
    endcase
  end

  assign add_sum   = adder(add_x, add_y, add_cin);
  assign add_res   = add_sum[WIDTH-1:0];
  assign add_v     = overflow(add_x[WIDTH-1], add_y[WIDTH-1], add_res[WIDTH-1]);
  assign logic_res = (opcode == OP_ANDS) ? (a & b) : (a | b);

  // One shift-add step. On the last step the remaining multiplier bit would
  // add (a << (WIDTH-1)), which only touches the MSB, so fold it in as an XOR
  // instead of spending another cycle on it.
  assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});
  assign prod   = acc_nx ^ {(mcand_q[WIDTH-2] & mplier_q[1]), {(WIDTH-1){1'b0}}};

  // Next-state logic for the FSM, output registers and multiplier datapath.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    nzcv_d      = nzcv_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (opcode)
            OP_ADD, OP_ADCS, OP_RSBS, OP_SBCS, OP_SUBS, OP_CMP: begin
              if (opcode != OP_CMP) begin
                result_d = add_res;
              end
              nzcv_d      = {add_res[WIDTH-1], (add_res == '0), add_sum[WIDTH], add_v};
              out_valid_d = 1'b1;
            end
            OP_ANDS, OP_ORRS: begin
              result_d    = logic_res;
              nzcv_d      = {logic_res[WIDTH-1], (logic_res == '0), nzcv_q[1:0]};
              out_valid_d = 1'b1;
            end
            OP_MULS: begin
              acc_d    = '0;
              mcand_d  = a;
              mplier_d = b;
              cnt_d    = CNT_INIT;
              state_d  = ST_MUL;
            end
            default: begin
              result_d    = '0;
              err_d       = 1'b1;
              out_valid_d = 1'b1;
            end
          endcase
        end
      end
      ST_MUL: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d    = prod;
          nzcv_d      = {prod[WIDTH-1], (prod == '0), nzcv_q[1:0]};
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Architectural state: FSM, visible outputs and flags, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      nzcv_q      <= 4'b0000;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      nzcv_q      <= nzcv_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  // Multiplier working registers; always reloaded on accept, so no reset.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    cnt_q    <= cnt_d;
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign nzcv      = nzcv_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq. The driver pushes the expected
// response of every accepted op into a queue; a negedge monitor pops and
// compares whenever out_valid is seen.
module tb_alu_seq;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   opcode = 4'd0;
  logic         out_valid;
  logic [W-1:0] result;
  logic [3:0]   nzcv;
  logic         err;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid),
    .result(result), .nzcv(nzcv), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   nzcv;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_res  = '0;
  logic [3:0]   m_nzcv = 4'b0000;
  int           tests = 0;
  int           fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // a + b + ci as integers: carry is unsigned overflow, V is signed overflow.
  function automatic void addm(input logic [W-1:0] x, input logic [W-1:0] y, input int ci,
                               output logic [W-1:0] r, output logic c, output logic v);
    longint u, s;
    u = longint'({{(64-W){1'b0}}, x}) + longint'({{(64-W){1'b0}}, y}) + longint'(ci);
    s = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    r = W'(u);
    c = (u > 64'sd4294967295);
    v = (s > SMAX) || (s < SMIN);
  endfunction

  // x - y - borrow as integers: C means no borrow (result non-negative).
  function automatic void subm(input logic [W-1:0] x, input logic [W-1:0] y, input int bw,
                               output logic [W-1:0] r, output logic c, output logic v);
    longint u, s;
    u = longint'({{(64-W){1'b0}}, x}) - longint'({{(64-W){1'b0}}, y}) - longint'(bw);
    s = longint'($signed(x)) - longint'($signed(y)) - longint'(bw);
    r = W'(u);
    c = (u >= 0);
    v = (s > SMAX) || (s < SMIN);
  endfunction

  task automatic model_push(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                            input int c);
    exp_t         e;
    logic [W-1:0] r;
    logic         cf, vf;
    int           cin;
    cin   = int'(m_nzcv[1]);
    e.err = 1'b0;
    e.cyc = c + 1;
    r = '0; cf = 1'b0; vf = 1'b0;
    case (op)
      4'd0: begin addm(x, y, 0, r, cf, vf);       m_res = r; m_nzcv = {r[W-1], r == '0, cf, vf}; end
      4'd1: begin addm(x, y, cin, r, cf, vf);     m_res = r; m_nzcv = {r[W-1], r == '0, cf, vf}; end
      4'd2: begin m_res = x & y; m_nzcv = {m_res[W-1], m_res == '0, m_nzcv[1:0]}; end
      4'd3: begin m_res = x | y; m_nzcv = {m_res[W-1], m_res == '0, m_nzcv[1:0]}; end
      4'd4: begin subm(y, x, 0, r, cf, vf);       m_res = r; m_nzcv = {r[W-1], r == '0, cf, vf}; end
      4'd5: begin subm(x, y, 1 - cin, r, cf, vf); m_res = r; m_nzcv = {r[W-1], r == '0, cf, vf}; end
      4'd6: begin subm(x, y, 0, r, cf, vf);       m_res = r; m_nzcv = {r[W-1], r == '0, cf, vf}; end
      4'd7: begin subm(x, y, 0, r, cf, vf);       m_nzcv = {r[W-1], r == '0, cf, vf}; end
      4'd8: begin
        m_res  = x * y;
        m_nzcv = {m_res[W-1], m_res == '0, m_nzcv[1:0]};
        e.cyc  = c + W;
      end
      default: begin m_res = '0; e.err = 1'b1; end
    endcase
    e.res  = m_res;
    e.nzcv = m_nzcv;
    sb.push_back(e);
  endtask

  // Present a request at a negedge and hold it until in_ready allows accept.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; opcode = op; a = x; b = y;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready=%0b after 200 cycles, required 1", in_ready);
    end else begin
      model_push(op, x, y, cyc);
    end
  endtask

  task automatic go_idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
    end
  endtask

  task automatic expect_now(input string name, input logic [W-1:0] r, input logic [3:0] f);
    chk({name, "_result"}, result, r);
    chk({name, "_nzcv"}, nzcv, f);
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: every out_valid pulse must match the oldest outstanding response.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_out_valid: got result=%0h nzcv=%b, required no output", result, nzcv);
      end else begin
        e = sb.pop_front();
        chk("sb_result", result, e.res);
        chk("sb_nzcv", nzcv, e.nzcv);
        chk("sb_err", err, e.err);
        chk("sb_latency_cycle", cyc, e.cyc);
      end
    end else if (err) begin
      chk("err_without_valid", err, 1'b0);
    end
  end

  initial begin
    int busy;
    logic [3:0] op;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_result", result, 0);
    chk("rst_nzcv", nzcv, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 1);

    issue(4'd0, 32'd15, 32'd10);                drain(); expect_now("add",    32'd25, 4'b0000);
    issue(4'd0, 32'hFFFF_FFFF, 32'd1);          drain(); expect_now("add_c",  32'd0,  4'b0110);
    issue(4'd0, 32'hFFFF_FFFF, 32'd1);
    issue(4'd1, 32'd15, 32'd10);                drain(); expect_now("adcs",   32'd26, 4'b0000);
    issue(4'd5, 32'd20, 32'd5);                 drain(); expect_now("sbcs",   32'd14, 4'b0010);
    issue(4'd6, 32'd20, 32'd5);                 drain(); expect_now("subs",   32'd15, 4'b0010);
    issue(4'd6, 32'd5, 32'd20);                 drain(); expect_now("subs_n", 32'hFFFF_FFF1, 4'b1000);
    issue(4'd6, 32'h8000_0000, 32'd1);          drain(); expect_now("subs_v", 32'h7FFF_FFFF, 4'b0011);
    issue(4'd2, 32'd12, 32'd5);                 drain(); expect_now("ands",   32'd4,  4'b0011);
    issue(4'd4, 32'd10, 32'd15);                drain(); expect_now("rsbs",   32'd5,  4'b0010);
    issue(4'd3, 32'd12, 32'd5);                 drain(); expect_now("orrs",   32'd13, 4'b0010);
    issue(4'd7, 32'd10, 32'd10);                drain(); expect_now("cmp",    32'd13, 4'b0110);

    // MULS with junk requests held on in_valid while busy.
    issue(4'd8, 32'd3, 32'd3);
    busy = 0;
    @(negedge clk);
    while (!in_ready && busy < 100) begin
      in_valid = 1'b1; opcode = 4'd0; a = W'($urandom); b = W'($urandom);
      busy++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("muls_busy_cycles", busy, 31);
    drain(); expect_now("muls", 32'd9, 4'b0010);
    issue(4'd8, 32'h0001_0000, 32'h0001_0000);  drain(); expect_now("muls_z", 32'd0, 4'b0110);

    issue(4'd6, 32'h8000_0000, 32'd1);
    issue(4'd10, 32'd7, 32'd9);                 drain(); expect_now("illegal", 32'd0, 4'b0011);

    // Reset in the middle of a multiply, with a request presented during reset.
    issue(4'd8, 32'd7, 32'd9);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b1; opcode = 4'd0; a = 32'd1; b = 32'd2;
    sb.delete();
    m_res = '0; m_nzcv = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("mulrst_result", result, 0);
    chk("mulrst_nzcv", nzcv, 0);
    chk("mulrst_in_ready", in_ready, 1);
    chk("mulrst_out_valid", out_valid, 0);
    go_idle(40);

    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      issue(op, rand_opnd(), rand_opnd());
      if ($urandom_range(0, 5) == 0) go_idle($urandom_range(0, 3));
    end
    drain();
    go_idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
